// File: rtl/execute_stage_if.sv
// Decode-to-execute bundle for execute_stage: D-stage controls and operands,
// forwarding inputs, pipeline control and the E-stage results.
interface execute_stage_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  StallE;
  logic                  FlushE;

  logic                  RegWriteD;
  logic                  MemWriteD;
  logic                  JumpD;
  logic                  BranchD;
  logic                  JalrD;
  logic                  ALUSrcD;
  logic [1:0]            ResultSrcD;
  logic [2:0]            ALUControlD;
  logic [2:0]            funct3D;
  logic [WIDTH-1:0]      RD1D;
  logic [WIDTH-1:0]      RD2D;
  logic [WIDTH-1:0]      ImmExtD;
  logic [WIDTH-1:0]      PCD;
  logic [WIDTH-1:0]      PCPlus4D;
  logic [REG_ADDR_W-1:0] Rs1D;
  logic [REG_ADDR_W-1:0] Rs2D;
  logic [REG_ADDR_W-1:0] RdD;

  logic [1:0]            ForwardAE;
  logic [1:0]            ForwardBE;
  logic [WIDTH-1:0]      ResultW;
  logic [WIDTH-1:0]      ALUResultM;

  logic [WIDTH-1:0]      ALUResultE;
  logic [WIDTH-1:0]      WriteDataE;
  logic [WIDTH-1:0]      PCTargetE;
  logic [WIDTH-1:0]      PCPlus4E;
  logic                  ZeroE;
  logic                  PCSrcE;
  logic                  RegWriteE;
  logic                  MemWriteE;
  logic                  ValidE;
  logic [1:0]            ResultSrcE;
  logic [REG_ADDR_W-1:0] Rs1E;
  logic [REG_ADDR_W-1:0] Rs2E;
  logic [REG_ADDR_W-1:0] RdE;

  modport master (
    output StallE, FlushE,
    output RegWriteD, MemWriteD, JumpD, BranchD, JalrD, ALUSrcD,
    output ResultSrcD, ALUControlD, funct3D,
    output RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
    output ForwardAE, ForwardBE, ResultW, ALUResultM,
    input  ALUResultE, WriteDataE, PCTargetE, PCPlus4E,
    input  ZeroE, PCSrcE, RegWriteE, MemWriteE, ValidE,
    input  ResultSrcE, Rs1E, Rs2E, RdE
  );

  modport slave (
    input  StallE, FlushE,
    input  RegWriteD, MemWriteD, JumpD, BranchD, JalrD, ALUSrcD,
    input  ResultSrcD, ALUControlD, funct3D,
    input  RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
    input  ForwardAE, ForwardBE, ResultW, ALUResultM,
    output ALUResultE, WriteDataE, PCTargetE, PCPlus4E,
    output ZeroE, PCSrcE, RegWriteE, MemWriteE, ValidE,
    output ResultSrcE, Rs1E, Rs2E, RdE
  );
endinterface

// File: rtl/execute_stage.sv
// ID/EX pipeline register plus execute logic of the RV32I core: operand
// forwarding, ALU, branch resolution and jump/branch target generation.
module execute_stage #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input logic           clk,
  input logic           rst_n,
  execute_stage_if.slave bus
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_SRL  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_PASS = 3'b110,
    ALU_SLL  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic                  jalr;
    logic                  alu_src;
    logic [1:0]            result_src;
    logic [2:0]            alu_ctrl;
    logic [2:0]            funct3;
    logic [WIDTH-1:0]      rd1;
    logic [WIDTH-1:0]      rd2;
    logic [WIDTH-1:0]      imm;
    logic [WIDTH-1:0]      pc;
    logic [WIDTH-1:0]      pc_plus4;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
  } idex_t;

  idex_t            capture;
  idex_t            idex_q;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] pc_target;
  logic             zero;
  logic             taken;

  always_comb begin
    capture            = '0;
    capture.valid      = 1'b1;
    capture.reg_write  = bus.RegWriteD;
    capture.mem_write  = bus.MemWriteD;
    capture.jump       = bus.JumpD;
    capture.branch     = bus.BranchD;
    capture.jalr       = bus.JalrD;
    capture.alu_src    = bus.ALUSrcD;
    capture.result_src = bus.ResultSrcD;
    capture.alu_ctrl   = bus.ALUControlD;
    capture.funct3     = bus.funct3D;
    capture.rd1        = bus.RD1D;
    capture.rd2        = bus.RD2D;
    capture.imm        = bus.ImmExtD;
    capture.pc         = bus.PCD;
    capture.pc_plus4   = bus.PCPlus4D;
    capture.rs1        = bus.Rs1D;
    capture.rs2        = bus.Rs2D;
    capture.rd         = bus.RdD;
  end

  // A flush clears data fields too, so a bubble is all-zero and flush beats stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q <= '0;
    end else if (bus.FlushE) begin
      idex_q <= '0;
    end else if (!bus.StallE) begin
      idex_q <= capture;
    end
  end

  always_comb begin
    src_a = idex_q.rd1;
    case (fwd_sel_e'(bus.ForwardAE))
      FWD_WB:  src_a = bus.ResultW;
      FWD_MEM: src_a = bus.ALUResultM;
      default: src_a = idex_q.rd1;
    endcase
  end

  always_comb begin
    write_data = idex_q.rd2;
    case (fwd_sel_e'(bus.ForwardBE))
      FWD_WB:  write_data = bus.ResultW;
      FWD_MEM: write_data = bus.ALUResultM;
      default: write_data = idex_q.rd2;
    endcase
  end

  assign src_b = idex_q.alu_src ? idex_q.imm : write_data;

  always_comb begin
    alu_result = '0;
    case (alu_op_e'(idex_q.alu_ctrl))
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_AND:  alu_result = src_a & src_b;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_SRL:  alu_result = src_a >> src_b[SHAMT_W-1:0];
      ALU_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_PASS: alu_result = src_b;
      ALU_SLL:  alu_result = src_a << src_b[SHAMT_W-1:0];
      default:  alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  always_comb begin
    taken = 1'b0;
    case (idex_q.funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      default: taken = 1'b0;
    endcase
  end

  assign pc_target = idex_q.jalr ? {alu_result[WIDTH-1:1], 1'b0}
                                 : idex_q.pc + idex_q.imm;

  assign bus.ALUResultE = alu_result;
  assign bus.WriteDataE = write_data;
  assign bus.PCTargetE  = pc_target;
  assign bus.PCPlus4E   = idex_q.pc_plus4;
  assign bus.ZeroE      = zero;
  assign bus.PCSrcE     = idex_q.valid & (idex_q.jump | (idex_q.branch & taken));
  assign bus.RegWriteE  = idex_q.reg_write;
  assign bus.MemWriteE  = idex_q.mem_write;
  assign bus.ValidE     = idex_q.valid;
  assign bus.ResultSrcE = idex_q.result_src;
  assign bus.Rs1E       = idex_q.rs1;
  assign bus.Rs2E       = idex_q.rs2;
  assign bus.RdE        = idex_q.rd;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, multi-cycle
// reset/flush/stall sequences and randomized traffic against a reference model.
module tb_execute_stage;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        jalr;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_ctrl;
    logic [2:0]  funct3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } d_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_target;
    logic [31:0] pc_plus4;
    logic        zero;
    logic        pc_src;
    logic        reg_write;
    logic        mem_write;
    logic        valid;
    logic [1:0]  result_src;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } o_t;

  typedef struct {
    string       name;
    d_t          d;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] resw;
    logic [31:0] alum;
    logic [31:0] exp_alu;
    logic [31:0] exp_target;
    logic        exp_pcsrc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state: the instruction currently held in EX and whether it is real.
  d_t          m_d;
  logic        m_valid;
  logic [1:0]  cur_fa, cur_fb;
  logic [31:0] cur_resw, cur_alum;

  execute_stage_if #(.WIDTH(32), .REG_ADDR_W(5)) bus ();

  execute_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] reg_val);
    if (sel == 2'b01) return cur_resw;
    if (sel == 2'b10) return cur_alum;
    return reg_val;
  endfunction

  function automatic o_t expected();
    o_t               o;
    logic [31:0]      a, b, wd;
    longint unsigned  ua, pw;
    int               sa, sb;
    logic             cond;
    a  = fwd(cur_fa, m_d.rd1);
    wd = fwd(cur_fb, m_d.rd2);
    b  = m_d.alu_src ? m_d.imm : wd;
    ua = longint'(a);
    pw = 64'd1 << b[4:0];
    sa = a;
    sb = b;
    o = '0;
    case (m_d.alu_ctrl)
      3'd0: o.alu_result = a + b;
      3'd1: o.alu_result = a - b;
      3'd2: o.alu_result = a & b;
      3'd3: o.alu_result = a | b;
      3'd4: o.alu_result = 32'(ua / pw);
      3'd5: o.alu_result = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: o.alu_result = b;
      default: o.alu_result = 32'(ua * pw);
    endcase
    o.zero       = (o.alu_result == 32'd0);
    o.write_data = wd;
    o.pc_target  = m_d.jalr ? (o.alu_result & 32'hFFFF_FFFE) : (m_d.pc + m_d.imm);
    o.pc_plus4   = m_d.pcp4;
    cond = (m_d.funct3 == 3'b000) ? o.zero : (m_d.funct3 == 3'b001) ? !o.zero : 1'b0;
    o.pc_src     = m_valid && (m_d.jump || (m_d.branch && cond));
    o.reg_write  = m_d.reg_write;
    o.mem_write  = m_d.mem_write;
    o.valid      = m_valid;
    o.result_src = m_d.result_src;
    o.rs1        = m_d.rs1;
    o.rs2        = m_d.rs2;
    o.rd         = m_d.rd;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    o_t e;
    e = expected();
    chk({tag, ".ALUResultE"}, bus.ALUResultE, e.alu_result);
    chk({tag, ".WriteDataE"}, bus.WriteDataE, e.write_data);
    chk({tag, ".PCTargetE"},  bus.PCTargetE,  e.pc_target);
    chk({tag, ".PCPlus4E"},   bus.PCPlus4E,   e.pc_plus4);
    chk({tag, ".ZeroE"},      32'(bus.ZeroE),      32'(e.zero));
    chk({tag, ".PCSrcE"},     32'(bus.PCSrcE),     32'(e.pc_src));
    chk({tag, ".RegWriteE"},  32'(bus.RegWriteE),  32'(e.reg_write));
    chk({tag, ".MemWriteE"},  32'(bus.MemWriteE),  32'(e.mem_write));
    chk({tag, ".ValidE"},     32'(bus.ValidE),     32'(e.valid));
    chk({tag, ".ResultSrcE"}, 32'(bus.ResultSrcE), 32'(e.result_src));
    chk({tag, ".Rs1E"},       32'(bus.Rs1E),       32'(e.rs1));
    chk({tag, ".Rs2E"},       32'(bus.Rs2E),       32'(e.rs2));
    chk({tag, ".RdE"},        32'(bus.RdE),        32'(e.rd));
  endtask

  task automatic set_fwd(input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] resw, input logic [31:0] alum);
    cur_fa = fa; cur_fb = fb; cur_resw = resw; cur_alum = alum;
    bus.ForwardAE  = fa;
    bus.ForwardBE  = fb;
    bus.ResultW    = resw;
    bus.ALUResultM = alum;
  endtask

  task automatic drive(input d_t d);
    bus.RegWriteD   = d.reg_write;
    bus.MemWriteD   = d.mem_write;
    bus.JumpD       = d.jump;
    bus.BranchD     = d.branch;
    bus.JalrD       = d.jalr;
    bus.ALUSrcD     = d.alu_src;
    bus.ResultSrcD  = d.result_src;
    bus.ALUControlD = d.alu_ctrl;
    bus.funct3D     = d.funct3;
    bus.RD1D        = d.rd1;
    bus.RD2D        = d.rd2;
    bus.ImmExtD     = d.imm;
    bus.PCD         = d.pc;
    bus.PCPlus4D    = d.pcp4;
    bus.Rs1D        = d.rs1;
    bus.Rs2D        = d.rs2;
    bus.RdD         = d.rd;
  endtask

  task automatic step(input d_t d, input logic stall, input logic flush);
    drive(d);
    bus.StallE = stall;
    bus.FlushE = flush;
    @(posedge clk);
    if (!rst_n || flush) begin
      m_d = '0;
      m_valid = 1'b0;
    end else if (!stall) begin
      m_d = d;
      m_valid = 1'b1;
    end
    #1;
  endtask

  function automatic d_t rand_d();
    d_t d;
    d.reg_write  = 1'($urandom);
    d.mem_write  = 1'($urandom);
    d.jump       = ($urandom_range(0, 3) == 0);
    d.branch     = 1'($urandom);
    d.jalr       = ($urandom_range(0, 3) == 0);
    d.alu_src    = 1'($urandom);
    d.result_src = 2'($urandom);
    d.alu_ctrl   = 3'($urandom);
    d.funct3     = 3'($urandom_range(0, 3));
    d.rd1        = $urandom;
    d.rd2        = ($urandom_range(0, 3) == 0) ? d.rd1 : $urandom;
    d.imm        = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    d.pc         = $urandom & 32'hFFFF_FFFC;
    d.pcp4       = d.pc + 32'd4;
    d.rs1        = 5'($urandom);
    d.rs2        = 5'($urandom);
    d.rd         = 5'($urandom);
    return d;
  endfunction

  vec_t vecs[12];

  initial begin
    d_t base, d, jmp;
    o_t snap;

    base = '0;
    base.reg_write = 1'b1;
    base.rs1 = 5'd1; base.rs2 = 5'd2; base.rd = 5'd3;
    base.pcp4 = 32'd4;

    for (int unsigned i = 0; i < 5; i++) begin
      vecs[i].d = base;
      vecs[i].d.rd1 = 32'hFFFF_FFF0;
      vecs[i].d.imm = 32'd4;
      vecs[i].d.alu_src = 1'b1;
      vecs[i].fa = 2'b00; vecs[i].fb = 2'b00;
      vecs[i].resw = 32'd9; vecs[i].alum = 32'd7;
      vecs[i].exp_target = 32'd4;
      vecs[i].exp_pcsrc = 1'b0;
    end
    vecs[0].name = "alu_add";  vecs[0].d.alu_ctrl = 3'b000; vecs[0].exp_alu = 32'hFFFF_FFF4;
    vecs[1].name = "alu_srl";  vecs[1].d.alu_ctrl = 3'b100; vecs[1].exp_alu = 32'h0FFF_FFFF;
    vecs[2].name = "alu_sll";  vecs[2].d.alu_ctrl = 3'b111; vecs[2].exp_alu = 32'hFFFF_FF00;
    vecs[3].name = "alu_slt";  vecs[3].d.alu_ctrl = 3'b101; vecs[3].exp_alu = 32'd1;
    vecs[4].name = "alu_pass"; vecs[4].d.alu_ctrl = 3'b110; vecs[4].exp_alu = 32'd4;

    for (int unsigned i = 5; i < 9; i++) begin
      vecs[i].d = base;
      vecs[i].d.rd1 = 32'd1;
      vecs[i].d.rd2 = 32'd2;
      vecs[i].d.alu_ctrl = 3'b001;
      vecs[i].resw = 32'd9; vecs[i].alum = 32'd7;
      vecs[i].exp_target = 32'd0;
      vecs[i].exp_pcsrc = 1'b0;
    end
    vecs[5].name = "fwd_a_mem";  vecs[5].fa = 2'b10; vecs[5].fb = 2'b00; vecs[5].exp_alu = 32'd5;
    vecs[6].name = "fwd_a_wb_b_mem"; vecs[6].fa = 2'b01; vecs[6].fb = 2'b10; vecs[6].exp_alu = 32'd2;
    vecs[7].name = "fwd_none";   vecs[7].fa = 2'b00; vecs[7].fb = 2'b00; vecs[7].exp_alu = 32'hFFFF_FFFF;
    vecs[8].name = "fwd_sel11";  vecs[8].fa = 2'b11; vecs[8].fb = 2'b11; vecs[8].exp_alu = 32'hFFFF_FFFF;

    for (int unsigned i = 9; i < 11; i++) begin
      vecs[i].d = base;
      vecs[i].d.reg_write = 1'b0;
      vecs[i].d.branch = 1'b1;
      vecs[i].d.rd1 = 32'd5; vecs[i].d.rd2 = 32'd5;
      vecs[i].d.alu_ctrl = 3'b001;
      vecs[i].d.pc = 32'h100; vecs[i].d.imm = 32'h20;
      vecs[i].fa = 2'b00; vecs[i].fb = 2'b00;
      vecs[i].resw = 32'd9; vecs[i].alum = 32'd7;
      vecs[i].exp_alu = 32'd0;
      vecs[i].exp_target = 32'h120;
    end
    vecs[9].name  = "beq_taken";    vecs[9].d.funct3  = 3'b000; vecs[9].exp_pcsrc  = 1'b1;
    vecs[10].name = "bne_nottaken"; vecs[10].d.funct3 = 3'b001; vecs[10].exp_pcsrc = 1'b0;

    vecs[11].name = "jalr";
    vecs[11].d = base;
    vecs[11].d.jalr = 1'b1; vecs[11].d.jump = 1'b1;
    vecs[11].d.rd1 = 32'h1003; vecs[11].d.imm = 32'd0;
    vecs[11].d.alu_ctrl = 3'b000; vecs[11].d.alu_src = 1'b1;
    vecs[11].fa = 2'b00; vecs[11].fb = 2'b00;
    vecs[11].resw = 32'd9; vecs[11].alum = 32'd7;
    vecs[11].exp_alu = 32'h1003; vecs[11].exp_target = 32'h1002; vecs[11].exp_pcsrc = 1'b1;

    // Reset state
    m_d = '0; m_valid = 1'b0;
    rst_n = 1'b0;
    bus.StallE = 1'b0; bus.FlushE = 1'b0;
    drive(base);
    set_fwd(2'b00, 2'b00, 32'd9, 32'd7);
    #12;
    chk("reset.ValidE", 32'(bus.ValidE), 32'd0);
    chk("reset.ALUResultE", bus.ALUResultE, 32'd0);
    chk("reset.ZeroE", 32'(bus.ZeroE), 32'd1);
    chk("reset.PCSrcE", 32'(bus.PCSrcE), 32'd0);
    chk("reset.PCTargetE", bus.PCTargetE, 32'd0);
    set_fwd(2'b00, 2'b01, 32'd9, 32'd7);
    #1;
    chk("reset.WriteDataE_fwd", bus.WriteDataE, 32'd9);
    set_fwd(2'b00, 2'b00, 32'd9, 32'd7);
    #2;
    rst_n = 1'b1;

    // First capture after reset release, then the directed table
    for (int unsigned i = 0; i < 12; i++) begin
      set_fwd(vecs[i].fa, vecs[i].fb, vecs[i].resw, vecs[i].alum);
      step(vecs[i].d, 1'b0, 1'b0);
      chk({vecs[i].name, ".alu"}, bus.ALUResultE, vecs[i].exp_alu);
      chk({vecs[i].name, ".target"}, bus.PCTargetE, vecs[i].exp_target);
      chk({vecs[i].name, ".pcsrc"}, 32'(bus.PCSrcE), 32'(vecs[i].exp_pcsrc));
      chk({vecs[i].name, ".valid"}, 32'(bus.ValidE), 32'd1);
      check_model(vecs[i].name);
    end

    // Asynchronous reset mid-cycle with a valid jump held in EX
    jmp = base;
    jmp.jump = 1'b1; jmp.rd1 = 32'h55; jmp.rd2 = 32'h3; jmp.pc = 32'h200; jmp.imm = 32'h40;
    set_fwd(2'b00, 2'b00, 32'd9, 32'd7);
    step(jmp, 1'b0, 1'b0);
    chk("pre_areset.PCSrcE", 32'(bus.PCSrcE), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    m_d = '0; m_valid = 1'b0;
    chk("areset.ValidE", 32'(bus.ValidE), 32'd0);
    chk("areset.PCSrcE", 32'(bus.PCSrcE), 32'd0);
    chk("areset.RegWriteE", 32'(bus.RegWriteE), 32'd0);
    chk("areset.ALUResultE", bus.ALUResultE, 32'd0);
    #2;
    rst_n = 1'b1;
    step(jmp, 1'b0, 1'b0);
    chk("post_reset.ValidE", 32'(bus.ValidE), 32'd1);
    check_model("post_reset");

    // Flush and stall together: flush wins
    d = rand_d();
    step(d, 1'b1, 1'b1);
    chk("flush_stall.ValidE", 32'(bus.ValidE), 32'd0);
    chk("flush_stall.PCSrcE", 32'(bus.PCSrcE), 32'd0);
    check_model("flush_stall");

    // Stall alone holds all outputs for three cycles while D inputs change
    set_fwd(2'b00, 2'b00, 32'd9, 32'd7);
    step(jmp, 1'b0, 1'b0);
    snap = expected();
    for (int unsigned k = 0; k < 3; k++) begin
      d = rand_d();
      step(d, 1'b1, 1'b0);
      chk("stall.ALUResultE", bus.ALUResultE, snap.alu_result);
      chk("stall.PCTargetE", bus.PCTargetE, snap.pc_target);
      chk("stall.PCSrcE", 32'(bus.PCSrcE), 32'(snap.pc_src));
      chk("stall.RdE", 32'(bus.RdE), 32'(snap.rd));
      check_model("stall");
    end

    // Randomized traffic
    for (int unsigned k = 0; k < 400; k++) begin
      set_fwd(2'($urandom), 2'($urandom), $urandom, $urandom);
      d = rand_d();
      step(d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      check_model("rand");
      set_fwd(2'($urandom), 2'($urandom), $urandom, $urandom);
      #1;
      check_model("rand_fwd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
